// File: rtl/jtdsp16_do_loop_if.sv
// Signal bundle between the DSP16 instruction decoder and the DO-loop sequencer.
// The master side is the decoder; the slave side is the loop sequencer.
interface jtdsp16_do_loop_if;
  logic        cen;
  logic        do_dec;
  logic        redo_dec;
  logic        ins_adv;
  logic [10:0] i_field;

  logic        do_start;
  logic        do_redo;
  logic        do_save;
  logic        do_out;
  logic        do_short;
  logic [10:0] do_data;
  logic [3:0]  do_pc;
  logic        irq_mask;
  logic [6:0]  debug_cnt;

  modport master (
    output cen, do_dec, redo_dec, ins_adv, i_field,
    input  do_start, do_redo, do_save, do_out, do_short, do_data, do_pc, irq_mask, debug_cnt
  );

  modport slave (
    input  cen, do_dec, redo_dec, ins_adv, i_field,
    output do_start, do_redo, do_save, do_out, do_short, do_data, do_pc, irq_mask, debug_cnt
  );
endinterface

// File: rtl/jtdsp16_do_loop.sv
// DO-loop sequencer: decodes `do K {NI}` / `redo K`, tracks the body position and the
// remaining pass count, and drives the loop strobes and cache offset used by the XAAU.
module jtdsp16_do_loop (
  input  logic               rst,
  input  logic               clk,
  jtdsp16_do_loop_if.slave   dl
);

  typedef enum logic {StIdle, StLoop} state_e;

  state_e     state_q, state_d;
  logic [3:0] ni_q, ni_d;
  logic [6:0] cnt_q, cnt_d;
  logic [3:0] pos_q, pos_d;
  logic [6:0] k_last_q, k_last_d;

  logic [3:0] ni_in;
  logic [6:0] k_in;
  logic       entry_ok;
  logic       adv;
  logic       last_ins;
  logic       last_pass;

  always_comb begin
    ni_in     = dl.i_field[10:7];
    k_in      = dl.i_field[6:0];
    // A redo reuses the stored body length, so it is only legal once a do has set one.
    entry_ok  = (state_q == StIdle) && dl.do_dec && dl.cen && (k_in != 7'd0) &&
                (dl.redo_dec ? (ni_q != 4'd0) : (ni_in != 4'd0));
    adv       = (state_q == StLoop) && dl.cen && dl.ins_adv;
    last_ins  = (pos_q == ni_q);
    last_pass = (cnt_q <= 7'd1);
  end

  always_comb begin
    state_d  = state_q;
    ni_d     = ni_q;
    cnt_d    = cnt_q;
    pos_d    = pos_q;
    k_last_d = k_last_q;
    unique case (state_q)
      StIdle: begin
        // ins_adv in the entry cycle belongs to the do itself and is not counted.
        if (entry_ok) begin
          if (!dl.redo_dec) ni_d = ni_in;
          cnt_d    = k_in;
          k_last_d = k_in;
          pos_d    = 4'd1;
          state_d  = StLoop;
        end
      end
      StLoop: begin
        if (adv) begin
          if (!last_ins) begin
            pos_d = pos_q + 4'd1;
          end else if (!last_pass) begin
            cnt_d = cnt_q - 7'd1;
            pos_d = 4'd1;
          end else begin
            cnt_d   = 7'd0;
            pos_d   = 4'd0;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      ni_q     <= 4'd0;
      cnt_q    <= 7'd0;
      pos_q    <= 4'd0;
      k_last_q <= 7'd0;
    end else begin
      state_q  <= state_d;
      ni_q     <= ni_d;
      cnt_q    <= cnt_d;
      pos_q    <= pos_d;
      k_last_q <= k_last_d;
    end
  end

  assign dl.do_start  = entry_ok;
  assign dl.do_redo   = entry_ok && dl.redo_dec;
  assign dl.do_save   = entry_ok && !dl.redo_dec;
  assign dl.do_out    = adv && last_ins && (cnt_q == 7'd1);
  assign dl.do_short  = (ni_q == 4'd1);
  assign dl.do_data   = {ni_q, k_last_q};
  assign dl.do_pc     = pos_q;
  assign dl.irq_mask  = (state_q == StLoop);
  assign dl.debug_cnt = cnt_q;

endmodule

// File: tb/tb_jtdsp16_do_loop.sv
// Directed bench for the DO-loop sequencer: a per-cycle vector table plus hand-written
// sequences for long loops, redo reuse and asynchronous reset mid-loop.
module tb_jtdsp16_do_loop;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  jtdsp16_do_loop_if dl ();

  jtdsp16_do_loop dut (
    .rst (rst),
    .clk (clk),
    .dl  (dl.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        cen;
    logic        dd;
    logic        rd;
    logic        adv;
    logic [10:0] fld;
    logic        e_start;
    logic        e_redo;
    logic        e_save;
    logic        e_out;
    logic [3:0]  e_pc;
    logic        e_mask;
    logic [6:0]  e_cnt;
    logic [10:0] e_data;
    logic        e_short;
  } vec_t;

  vec_t vecs[19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive inputs just after the falling edge, then settle before sampling.
  task automatic drive(input logic cen, input logic dd, input logic rd, input logic adv,
                       input logic [10:0] fld);
    @(negedge clk);
    dl.cen      = cen;
    dl.do_dec   = dd;
    dl.redo_dec = rd;
    dl.ins_adv  = adv;
    dl.i_field  = fld;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_strobes(input string tag, input logic s, input logic r, input logic sv,
                             input logic o);
    chk({tag, " strobes{start,redo,save,out}"},
        {28'd0, dl.do_start, dl.do_redo, dl.do_save, dl.do_out}, {28'd0, s, r, sv, o});
  endtask

  task automatic chk_regs(input string tag, input logic [3:0] pc, input logic mask,
                          input logic [6:0] cnt, input logic [10:0] data, input logic sh);
    chk({tag, " do_pc"}, 32'(dl.do_pc), 32'(pc));
    chk({tag, " irq_mask"}, 32'(dl.irq_mask), 32'(mask));
    chk({tag, " debug_cnt"}, 32'(dl.debug_cnt), 32'(cnt));
    chk({tag, " do_data"}, 32'(dl.do_data), 32'(data));
    chk({tag, " do_short"}, 32'(dl.do_short), 32'(sh));
  endtask

  initial begin
    checks = 0;
    errors = 0;

    //          cen dd rd adv fld      st rd sv out pc mk cnt data    sh
    vecs[0]  = '{1, 1, 0, 1, 11'h182, 1, 0, 1, 0, 1, 1, 2, 11'h182, 0};
    vecs[1]  = '{1, 0, 0, 1, 11'h000, 0, 0, 0, 0, 2, 1, 2, 11'h182, 0};
    vecs[2]  = '{1, 0, 0, 1, 11'h000, 0, 0, 0, 0, 3, 1, 2, 11'h182, 0};
    vecs[3]  = '{1, 0, 0, 1, 11'h000, 0, 0, 0, 0, 1, 1, 1, 11'h182, 0};
    vecs[4]  = '{1, 0, 0, 1, 11'h000, 0, 0, 0, 0, 2, 1, 1, 11'h182, 0};
    vecs[5]  = '{1, 0, 0, 1, 11'h000, 0, 0, 0, 0, 3, 1, 1, 11'h182, 0};
    // do_dec coincident with do_out is ignored
    vecs[6]  = '{1, 1, 0, 1, 11'h081, 0, 0, 0, 1, 0, 0, 0, 11'h182, 0};
    vecs[7]  = '{1, 1, 0, 0, 11'h081, 1, 0, 1, 0, 1, 1, 1, 11'h081, 1};
    vecs[8]  = '{1, 0, 0, 1, 11'h000, 0, 0, 0, 1, 0, 0, 0, 11'h081, 1};
    vecs[9]  = '{1, 1, 0, 0, 11'h100, 0, 0, 0, 0, 0, 0, 0, 11'h081, 1};
    vecs[10] = '{1, 1, 0, 0, 11'h005, 0, 0, 0, 0, 0, 0, 0, 11'h081, 1};
    vecs[11] = '{1, 1, 1, 0, 11'h003, 1, 1, 0, 0, 1, 1, 3, 11'h083, 1};
    vecs[12] = '{0, 0, 0, 1, 11'h000, 0, 0, 0, 0, 1, 1, 3, 11'h083, 1};
    vecs[13] = '{1, 0, 0, 0, 11'h000, 0, 0, 0, 0, 1, 1, 3, 11'h083, 1};
    vecs[14] = '{1, 0, 0, 1, 11'h000, 0, 0, 0, 0, 1, 1, 2, 11'h083, 1};
    vecs[15] = '{1, 1, 0, 0, 11'h102, 0, 0, 0, 0, 1, 1, 2, 11'h083, 1};
    vecs[16] = '{1, 0, 0, 1, 11'h000, 0, 0, 0, 0, 1, 1, 1, 11'h083, 1};
    vecs[17] = '{1, 0, 0, 1, 11'h000, 0, 0, 0, 1, 0, 0, 0, 11'h083, 1};
    vecs[18] = '{0, 1, 0, 0, 11'h182, 0, 0, 0, 0, 0, 0, 0, 11'h083, 1};

    dl.cen      = 1'b0;
    dl.do_dec   = 1'b0;
    dl.redo_dec = 1'b0;
    dl.ins_adv  = 1'b0;
    dl.i_field  = 11'd0;
    rst         = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_strobes("reset", 0, 0, 0, 0);
    chk_regs("reset", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    // redo straight after reset has no stored body length
    drive(1, 1, 1, 0, 11'h105);
    chk_strobes("redo_after_reset", 0, 0, 0, 0);
    tick();
    chk_regs("redo_after_reset", 0, 0, 0, 0, 0);

    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].cen, vecs[i].dd, vecs[i].rd, vecs[i].adv, vecs[i].fld);
      chk_strobes($sformatf("vec%0d", i), vecs[i].e_start, vecs[i].e_redo, vecs[i].e_save,
                  vecs[i].e_out);
      tick();
      chk_regs($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_mask, vecs[i].e_cnt,
               vecs[i].e_data, vecs[i].e_short);
    end

    // NI=1, K=127: counter walks 127..1, do_pc pinned at 1
    drive(1, 1, 0, 0, {4'd1, 7'd127});
    chk_strobes("k127_entry", 1, 0, 1, 0);
    tick();
    chk_regs("k127_entry", 1, 1, 127, {4'd1, 7'd127}, 1);
    for (int i = 0; i < 127; i++) begin
      drive(1, 0, 0, 1, 11'd0);
      chk(.name($sformatf("k127 cnt adv%0d", i)), .act(32'(dl.debug_cnt)), .exp(32'(127 - i)));
      chk(.name($sformatf("k127 do_out adv%0d", i)), .act(32'(dl.do_out)),
          .exp(32'(i == 126)));
      if (i < 126) chk(.name($sformatf("k127 do_pc adv%0d", i)), .act(32'(dl.do_pc)), .exp(1));
      tick();
    end
    chk_regs("k127_done", 0, 0, 0, {4'd1, 7'd127}, 1);

    // NI=4, K=1 loop, then redo K=5 reuses NI=4 without a head capture
    drive(1, 1, 0, 0, {4'd4, 7'd1});
    chk_strobes("ni4_entry", 1, 0, 1, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 1, 11'd0);
      tick();
    end
    chk_regs("ni4_done", 0, 0, 0, {4'd4, 7'd1}, 0);
    drive(1, 1, 1, 0, 11'd5);
    chk_strobes("redo5_entry", 1, 1, 0, 0);
    tick();
    chk_regs("redo5_entry", 1, 1, 5, {4'd4, 7'd5}, 0);
    for (int i = 0; i < 20; i++) begin
      drive(1, 0, 0, 1, 11'd0);
      chk(.name($sformatf("redo5 do_pc adv%0d", i)), .act(32'(dl.do_pc)), .exp(32'((i % 4) + 1)));
      chk(.name($sformatf("redo5 do_out adv%0d", i)), .act(32'(dl.do_out)), .exp(32'(i == 19)));
      tick();
    end
    chk_regs("redo5_done", 0, 0, 0, {4'd4, 7'd5}, 0);

    // Async reset during pass 2 of NI=2, K=3; later redo is ignored
    drive(1, 1, 0, 0, {4'd2, 7'd3});
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 1, 11'd0);
      tick();
    end
    chk_regs("pass2", 2, 1, 2, {4'd2, 7'd3}, 0);
    drive(0, 0, 0, 0, 11'd0);
    rst = 1'b1;
    #1;
    chk_regs("async_rst", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    drive(1, 1, 1, 0, 11'd3);
    chk_strobes("redo_after_rst", 0, 0, 0, 0);
    tick();
    chk_regs("redo_after_rst", 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
